// File: rtl/wash_pkg.sv
// Shared types, constants and small decode helpers for the wash sequencer.
package wash_pkg;

    localparam int REMAIN_W = 7;

    localparam logic [3:0] WASH_TICKS  = 4'd9;
    localparam logic [3:0] RINSE_TICKS = 4'd6;
    localparam logic [3:0] SPIN_TICKS  = 4'd3;

    localparam logic [2:0] L_MIN = 3'd1;
    localparam logic [2:0] L_MAX = 3'd5;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FILL   = 4'd1,
        WASH   = 4'd2,
        DRAIN1 = 4'd3,
        RFILL  = 4'd4,
        RINSE  = 4'd5,
        DRAIN2 = 4'd6,
        SPIN   = 4'd7,
        DONE   = 4'd8
    } phase_t;

    typedef struct packed {
        logic inwater;
        logic outwater;
        logic wash_on;
        logic rinse_on;
        logic dry_on;
        logic running;
        logic finish;
    } out_flags_t;

    function automatic logic [2:0] clamp_level(input logic [2:0] lvl);
        if (lvl < L_MIN) begin
            return L_MIN;
        end else if (lvl > L_MAX) begin
            return L_MAX;
        end else begin
            return lvl;
        end
    endfunction

    // From IDLE/DONE this yields the first enabled stage; otherwise the successor.
    function automatic phase_t next_stage(input phase_t cur, input logic [2:0] mask);
        case (cur)
            FILL:    return WASH;
            WASH:    return DRAIN1;
            DRAIN1:  return mask[1] ? RFILL : (mask[0] ? SPIN : DONE);
            RFILL:   return RINSE;
            RINSE:   return DRAIN2;
            DRAIN2:  return mask[0] ? SPIN : DONE;
            SPIN:    return DONE;
            IDLE, DONE: return mask[2] ? FILL : (mask[1] ? RFILL : (mask[0] ? SPIN : IDLE));
            default: return IDLE;
        endcase
    endfunction

    function automatic logic [3:0] stage_ticks(input phase_t stage, input logic [2:0] lvl);
        case (stage)
            FILL, DRAIN1, RFILL, DRAIN2: return {1'b0, lvl};
            WASH:    return WASH_TICKS;
            RINSE:   return RINSE_TICKS;
            SPIN:    return SPIN_TICKS;
            default: return 4'd0;
        endcase
    endfunction

    function automatic out_flags_t decode_flags(input phase_t stage, input logic paused);
        out_flags_t f;
        f = '0;
        case (stage)
            FILL, RFILL:    begin f.inwater  = ~paused; f.running = 1'b1; end
            DRAIN1, DRAIN2: begin f.outwater = ~paused; f.running = 1'b1; end
            WASH:           begin f.wash_on  = ~paused; f.running = 1'b1; end
            RINSE:          begin f.rinse_on = ~paused; f.running = 1'b1; end
            SPIN:           begin f.dry_on   = ~paused; f.running = 1'b1; end
            DONE:           f.finish = 1'b1;
            default:        f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter for the current stage; expire flags the tick that ends it.
module phase_timer
    import wash_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       tick,
    input  logic       hold,
    output logic       expire
);

    logic [3:0] count_r;

    assign expire = tick & ~hold & (count_r == 4'd1);

    // Stage countdown; a load always wins over a tick in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_value;
        end else if (tick && !hold && count_r != 4'd0) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// Washing machine stage sequencer with pause and remaining-time display.
// Define WASH_SEQ_BUZZER_EN to build the end-of-cycle buzzer.
module wash_sequencer
    import wash_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_1hz,
    input  logic                start_pulse,
    input  logic [2:0]          model,
    input  logic [2:0]          water_level,
    output logic [3:0]          phase,
    output logic                inwater,
    output logic                outwater,
    output logic                wash_on,
    output logic                rinse_on,
    output logic                dry_on,
    output logic                running,
    output logic                paused,
    output logic                finish,
    output logic [REMAIN_W-1:0] remain_time,
    output logic                buzzer
);

    phase_t              state_r;
    logic                paused_r;
    logic [REMAIN_W-1:0] remain_r;
    logic [2:0]          model_r;
    logic [2:0]          level_r;
    out_flags_t          flags_r;

    logic                idle_s;
    logic                start_ok_s;
    logic [2:0]          mask_s;
    logic [2:0]          lvl_s;
    phase_t              target_s;
    logic                expire_s;
    logic                load_s;
    logic [REMAIN_W-1:0] remain_load_s;

    assign idle_s     = (state_r == IDLE) || (state_r == DONE);
    assign start_ok_s = idle_s & start_pulse & (model != 3'd0);
    assign mask_s     = idle_s ? model : model_r;
    assign lvl_s      = idle_s ? clamp_level(water_level) : level_r;
    assign target_s   = next_stage(state_r, mask_s);
    assign load_s     = start_ok_s | expire_s;

    phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .load_value (stage_ticks(target_s, lvl_s)),
        .tick       (tick_1hz),
        .hold       (paused_r | start_pulse),
        .expire     (expire_s)
    );

    // Sum of the entered stage plus every enabled stage after it.
    always_comb begin
        logic [REMAIN_W-1:0] l7_s;
        logic [REMAIN_W-1:0] rinse_part_s;
        logic [REMAIN_W-1:0] spin_part_s;
        l7_s          = {4'd0, lvl_s};
        rinse_part_s  = mask_s[1] ? (l7_s + l7_s + 7'd6) : 7'd0;
        spin_part_s   = mask_s[0] ? 7'd3 : 7'd0;
        remain_load_s = 7'd0;
        case (target_s)
            FILL:    remain_load_s = l7_s + 7'd9 + l7_s + rinse_part_s + spin_part_s;
            WASH:    remain_load_s = 7'd9 + l7_s + rinse_part_s + spin_part_s;
            DRAIN1:  remain_load_s = l7_s + rinse_part_s + spin_part_s;
            RFILL:   remain_load_s = l7_s + 7'd6 + l7_s + spin_part_s;
            RINSE:   remain_load_s = 7'd6 + l7_s + spin_part_s;
            DRAIN2:  remain_load_s = l7_s + spin_part_s;
            SPIN:    remain_load_s = 7'd3;
            default: remain_load_s = 7'd0;
        endcase
    end

    // Sequencer FSM: start/pause handling, stage advance and registered decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            paused_r <= 1'b0;
            remain_r <= '0;
            model_r  <= 3'd0;
            level_r  <= 3'd0;
            flags_r  <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start_ok_s) begin
                        model_r  <= model;
                        level_r  <= lvl_s;
                        state_r  <= target_s;
                        paused_r <= 1'b0;
                        remain_r <= remain_load_s;
                        flags_r  <= decode_flags(target_s, 1'b0);
                    end
                end
                default: begin
                    if (start_pulse) begin
                        paused_r <= ~paused_r;
                        flags_r  <= decode_flags(state_r, ~paused_r);
                    end else if (tick_1hz && !paused_r) begin
                        if (expire_s) begin
                            state_r  <= target_s;
                            remain_r <= remain_load_s;
                            flags_r  <= decode_flags(target_s, 1'b0);
                        end else if (remain_r != 7'd0) begin
                            remain_r <= remain_r - 7'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign phase       = state_r;
    assign paused      = paused_r;
    assign remain_time = remain_r;
    assign inwater     = flags_r.inwater;
    assign outwater    = flags_r.outwater;
    assign wash_on     = flags_r.wash_on;
    assign rinse_on    = flags_r.rinse_on;
    assign dry_on      = flags_r.dry_on;
    assign running     = flags_r.running;
    assign finish      = flags_r.finish;

`ifdef WASH_SEQ_BUZZER_EN
    logic       buzzer_r;
    logic [1:0] buzz_cnt_r;
    logic       enter_done_s;

    assign enter_done_s = expire_s & (target_s == DONE);

    // Buzzer sounds for three ticks after the cycle completes.
    always_ff @(posedge clk) begin
        if (reset || start_pulse) begin
            buzzer_r   <= 1'b0;
            buzz_cnt_r <= 2'd0;
        end else if (enter_done_s) begin
            buzzer_r   <= 1'b1;
            buzz_cnt_r <= 2'd3;
        end else if (buzzer_r && tick_1hz) begin
            buzzer_r   <= (buzz_cnt_r != 2'd1);
            buzz_cnt_r <= buzz_cnt_r - 2'd1;
        end else begin
            buzzer_r   <= buzzer_r;
            buzz_cnt_r <= buzz_cnt_r;
        end
    end

    assign buzzer = buzzer_r;
`else
    assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed self-checking bench for wash_sequencer (buzzer checks follow WASH_SEQ_BUZZER_EN).
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       start_pulse = 1'b0;
    logic [2:0] model = 3'd0;
    logic [2:0] water_level = 3'd0;
    logic [3:0] phase;
    logic       inwater, outwater, wash_on, rinse_on, dry_on, running;
    logic       paused, finish, buzzer;
    logic [6:0] remain_time;

    int checks = 0;
    int errors = 0;

    wash_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .start_pulse (start_pulse),
        .model       (model),
        .water_level (water_level),
        .phase       (phase),
        .inwater     (inwater),
        .outwater    (outwater),
        .wash_on     (wash_on),
        .rinse_on    (rinse_on),
        .dry_on      (dry_on),
        .running     (running),
        .paused      (paused),
        .finish      (finish),
        .remain_time (remain_time),
        .buzzer      (buzzer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_1hz = 1'b1;
            @(negedge clk) tick_1hz = 1'b0;
        end
    endtask

    task automatic start();
        @(negedge clk) start_pulse = 1'b1;
        @(negedge clk) start_pulse = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_remain"}, remain_time, 0);
        check({tag, "_outs"}, {inwater, outwater, wash_on, rinse_on, dry_on,
                               running, paused, finish, buzzer}, 0);
    endtask

    int exp_ph[7] = '{1, 2, 3, 4, 5, 6, 7};
    int exp_du[7] = '{2, 9, 2, 2, 6, 2, 3};
    int rem;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Full cycle, model 111, L = 2
        model = 3'b111; water_level = 3'd2;
        start();
        rem = 26;
        for (int s = 0; s < 7; s++) begin
            check("a_phase", phase, exp_ph[s]);
            check("a_remain_entry", remain_time, rem);
            check("a_inwater", inwater, (exp_ph[s] == 1 || exp_ph[s] == 4));
            check("a_outwater", outwater, (exp_ph[s] == 3 || exp_ph[s] == 6));
            check("a_wash_on", wash_on, (exp_ph[s] == 2));
            check("a_rinse_on", rinse_on, (exp_ph[s] == 5));
            check("a_dry_on", dry_on, (exp_ph[s] == 7));
            check("a_running", running, 1);
            for (int t = 0; t < exp_du[s]; t++) begin
                tick(1);
                rem--;
                check("a_remain_tick", remain_time, rem);
            end
        end
        check("a_done_phase", phase, 8);
        check("a_finish", finish, 1);
        check("a_done_running", running, 0);
`ifdef WASH_SEQ_BUZZER_EN
        check("a_buzz_on", buzzer, 1);
        tick(2);
        check("a_buzz_2ticks", buzzer, 1);
        tick(1);
        check("a_buzz_off", buzzer, 0);
`else
        check("a_buzz_off", buzzer, 0);
        tick(3);
        check("a_buzz_off_later", buzzer, 0);
`endif
        check("a_done_hold", phase, 8);

        // Wash only, water_level 7 clamps to 5
        model = 3'b100; water_level = 3'd7;
        start();
        check("c_phase", phase, 1);
        check("c_remain_l5", remain_time, 19);
        tick(5);
        check("c_wash_after_l5", phase, 2);
        check("c_remain_14", remain_time, 14);
        tick(14);
        check("c_done", phase, 8);
        check("c_remain_0", remain_time, 0);
`ifdef WASH_SEQ_BUZZER_EN
        check("c_buzz_on", buzzer, 1);
`endif
        // Restart with water_level 0 clamps to 1; buzzer clears at once
        water_level = 3'd0;
        start();
        check("c_buzz_clear", buzzer, 0);
        check("c_phase_l1", phase, 1);
        check("c_remain_l1", remain_time, 11);
        tick(1);
        check("c_wash_after_l1", phase, 2);
        tick(10);
        check("c_done_l1", phase, 8);

        // Spin only, water level irrelevant and changes ignored
        model = 3'b001; water_level = 3'd4;
        start();
        check("b_phase", phase, 7);
        check("b_remain", remain_time, 3);
        check("b_dry_on", dry_on, 1);
        water_level = 3'd1; model = 3'b100;
        tick(2);
        check("b_still_spin", phase, 7);
        check("b_remain_1", remain_time, 1);
        tick(1);
        check("b_done", phase, 8);
        check("b_finish", finish, 1);

        // Pause during WASH at remain 20, start coinciding with a tick
        model = 3'b111; water_level = 3'd2;
        start();
        tick(6);
        check("d_wash", phase, 2);
        check("d_remain_20", remain_time, 20);
        @(negedge clk) begin start_pulse = 1'b1; tick_1hz = 1'b1; end
        @(negedge clk) begin start_pulse = 1'b0; tick_1hz = 1'b0; end
        check("d_paused", paused, 1);
        check("d_wash_off", wash_on, 0);
        check("d_remain_hold", remain_time, 20);
        tick(10);
        check("d_remain_hold10", remain_time, 20);
        check("d_phase_hold", phase, 2);
        check("d_running_paused", running, 1);
        start();
        check("d_resumed", paused, 0);
        check("d_wash_back", wash_on, 1);
        check("d_remain_resume", remain_time, 20);
        tick(5);
        check("d_drain1", phase, 3);
        check("d_remain_15", remain_time, 15);
        check("d_outwater", outwater, 1);

        // Reset in the middle of RINSE
        tick(4);
        check("e_rinse", phase, 5);
        check("e_remain_11", remain_time, 11);
        tick(2);
        check("e_remain_9", remain_time, 9);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check_idle_outputs("e_reset");
        model = 3'b000; water_level = 3'd3;
        start();
        check_idle_outputs("e_model0");
        tick(2);
        check("e_model0_stay", phase, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
